// File: rtl/rs_oldest_issue_scheduler_if.sv
// Handshake bundle between a reservation-station scheduler and its producer/consumer.
// The master side drives allocation, wakeup, flush and issue-ready; the slave is the scheduler.
interface rs_oldest_issue_scheduler_if #(
  parameter int unsigned ENTLEN = 2,
  parameter int unsigned TAGLEN = 6,
  parameter int unsigned PAYLEN = 32
);
  logic                flush_i;
  logic                alloc_valid_i;
  logic                alloc_ready_o;
  logic [TAGLEN-1:0]   alloc_src1_tag_i;
  logic                alloc_src1_rdy_i;
  logic [TAGLEN-1:0]   alloc_src2_tag_i;
  logic                alloc_src2_rdy_i;
  logic [PAYLEN-1:0]   alloc_payload_i;
  logic [1:0]          wakeup_valid_i;
  logic [2*TAGLEN-1:0] wakeup_tag_i;
  logic                issue_valid_o;
  logic                issue_ready_i;
  logic [ENTLEN-1:0]   issue_entry_o;
  logic [PAYLEN-1:0]   issue_payload_o;
  logic [ENTLEN:0]     count_o;

  modport master (
    output flush_i, alloc_valid_i, alloc_src1_tag_i, alloc_src1_rdy_i, alloc_src2_tag_i,
           alloc_src2_rdy_i, alloc_payload_i, wakeup_valid_i, wakeup_tag_i, issue_ready_i,
    input  alloc_ready_o, issue_valid_o, issue_entry_o, issue_payload_o, count_o
  );

  modport slave (
    input  flush_i, alloc_valid_i, alloc_src1_tag_i, alloc_src1_rdy_i, alloc_src2_tag_i,
           alloc_src2_rdy_i, alloc_payload_i, wakeup_valid_i, wakeup_tag_i, issue_ready_i,
    output alloc_ready_o, issue_valid_o, issue_entry_o, issue_payload_o, count_o
  );
endinterface

// File: rtl/rs_oldest_issue_scheduler.sv
// Reservation-station scheduler: buffers uops, wakes sources by tag broadcast and issues the
// oldest fully-ready entry. Age is a dense per-entry rank (0 = oldest) so selection is a min.
module rs_oldest_issue_scheduler #(
  parameter int unsigned ENTNUM = 4,
  parameter int unsigned ENTLEN = 2,
  parameter int unsigned TAGLEN = 6,
  parameter int unsigned PAYLEN = 32
) (
  input logic                       clk_i,
  input logic                       rst_n_i,
  rs_oldest_issue_scheduler_if.slave bus_io
);

  logic [ENTNUM-1:0] valid_q;
  logic [ENTNUM-1:0] src1_rdy_q;
  logic [ENTNUM-1:0] src2_rdy_q;
  logic [TAGLEN-1:0] src1_tag_q [ENTNUM];
  logic [TAGLEN-1:0] src2_tag_q [ENTNUM];
  logic [PAYLEN-1:0] payload_q  [ENTNUM];
  logic [ENTLEN-1:0] rank_q     [ENTNUM];
  logic [ENTLEN:0]   count_q;

  logic              sel_found;
  logic [ENTLEN-1:0] sel_idx;
  logic [ENTLEN-1:0] sel_rank;
  logic              free_found;
  logic [ENTLEN-1:0] free_idx;
  logic              alloc_ready;
  logic              alloc_fire;
  logic              issue_fire;
  logic              alloc_wake1;
  logic              alloc_wake2;
  logic [ENTLEN-1:0] alloc_rank;
  logic [ENTNUM-1:0] wake1;
  logic [ENTNUM-1:0] wake2;

  function automatic logic tag_hit(logic [TAGLEN-1:0] tag, logic [1:0] wv,
                                   logic [2*TAGLEN-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (wv[k] && (wt[k*TAGLEN +: TAGLEN] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rank  = '0;
    for (int i = 0; i < ENTNUM; i++) begin
      if (valid_q[i] && src1_rdy_q[i] && src2_rdy_q[i] &&
          (!sel_found || (rank_q[i] < sel_rank))) begin
        sel_found = 1'b1;
        sel_idx   = ENTLEN'(i);
        sel_rank  = rank_q[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTNUM; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = ENTLEN'(i);
      end
    end
  end

  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < ENTNUM; i++) begin
      wake1[i] = tag_hit(src1_tag_q[i], bus_io.wakeup_valid_i, bus_io.wakeup_tag_i);
      wake2[i] = tag_hit(src2_tag_q[i], bus_io.wakeup_valid_i, bus_io.wakeup_tag_i);
    end
  end

  assign alloc_wake1 = tag_hit(bus_io.alloc_src1_tag_i, bus_io.wakeup_valid_i,
                               bus_io.wakeup_tag_i);
  assign alloc_wake2 = tag_hit(bus_io.alloc_src2_tag_i, bus_io.wakeup_valid_i,
                               bus_io.wakeup_tag_i);

  // Space is judged on the current count only; a same-cycle issue does not make room.
  assign alloc_ready = count_q < (ENTLEN+1)'(ENTNUM);
  assign alloc_fire  = bus_io.alloc_valid_i & alloc_ready & ~bus_io.flush_i;
  assign issue_fire  = sel_found & bus_io.issue_ready_i & ~bus_io.flush_i;
  // Youngest rank after any same-cycle issue has compacted the older ranks.
  assign alloc_rank  = ENTLEN'(count_q - (ENTLEN+1)'(issue_fire));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      count_q    <= '0;
      for (int i = 0; i < ENTNUM; i++) rank_q[i] <= '0;
    end else if (bus_io.flush_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ENTNUM; i++) begin
        if (wake1[i]) src1_rdy_q[i] <= 1'b1;
        if (wake2[i]) src2_rdy_q[i] <= 1'b1;
        if (issue_fire && (rank_q[i] > sel_rank)) rank_q[i] <= rank_q[i] - ENTLEN'(1);
      end
      if (issue_fire) valid_q[sel_idx] <= 1'b0;
      // Free slot is never the issuing one, so these writes do not collide with the above.
      if (alloc_fire) begin
        valid_q[free_idx]    <= 1'b1;
        src1_rdy_q[free_idx] <= bus_io.alloc_src1_rdy_i | alloc_wake1;
        src2_rdy_q[free_idx] <= bus_io.alloc_src2_rdy_i | alloc_wake2;
        rank_q[free_idx]     <= alloc_rank;
      end
      count_q <= count_q + (ENTLEN+1)'(alloc_fire) - (ENTLEN+1)'(issue_fire);
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      src1_tag_q[free_idx] <= bus_io.alloc_src1_tag_i;
      src2_tag_q[free_idx] <= bus_io.alloc_src2_tag_i;
      payload_q[free_idx]  <= bus_io.alloc_payload_i;
    end
  end

  assign bus_io.alloc_ready_o   = alloc_ready;
  assign bus_io.issue_valid_o   = sel_found;
  assign bus_io.issue_entry_o   = sel_found ? sel_idx : '0;
  assign bus_io.issue_payload_o = sel_found ? payload_q[sel_idx] : '0;
  assign bus_io.count_o         = count_q;

endmodule
